uart_rx_sel_decoder: RTL
========================

# uart_rx_sel_decoder

UART receive path that undoes the transmit-side character mapping: it deserialises 8N1 frames from the serial line and decodes ASCII 'A'..'P' (0x41..0x50) back to the 4-bit selector 0..15. It sits at the receive pin of the UART test design, opposite the transmitter that sends the selector as an ASCII letter. Its outputs drive the selector consumer, such as LEDs or a loopback checker.

## Interface
- CLK_FREQ, 50_000_000: system clock frequency in Hz.
- BAUD, 9600: line rate in bit/s.
- CLKS_PER_BIT (localparam) = CLK_FREQ/BAUD, integer-truncated; must be ≥ 4.
- HALF_BIT (localparam) = CLKS_PER_BIT/2, integer-truncated.

- clk  input  1  system clock; all logic is on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- rxd  input  1  serial line, idle high; asynchronous to clk.
- rx_byte  output  8  last byte whose stop bit was sampled, held until the next such byte.
- sel_out  output  4  last successfully decoded selector, held until the next valid character.
- sel_valid  output  1  one-cycle pulse when sel_out updates.
- char_err  output  1  one-cycle pulse when a well-framed byte lies outside 0x41..0x50.
- frame_err  output  1  one-cycle pulse when the stop bit is sampled low.
- busy  output  1  high in every state except IDLE.

## Operation
- Synchroniser: rxd passes through 2 flops, both reset to 1. All logic uses only the synchronised value rxs and its previous value rxs_d, which also resets to 1.
- FSM states are IDLE, START, DATA and STOP. A bit counter (log2 CLKS_PER_BIT bits) and a 3-bit index control sampling.
- IDLE: when rxs_d=1 and rxs=0 (falling edge), clear the counter and go to START.
- START: when the counter reaches HALF_BIT-1, sample rxs.
  - rxs=1: treat as a glitch and return to IDLE with no outputs.
  - rxs=0: clear the counter and index, then go to DATA.
- DATA: each time the counter reaches CLKS_PER_BIT-1, shift rxs into the shift register LSB-first and increment the index. After index 7 is sampled, go to STOP.
- STOP: when the counter reaches CLKS_PER_BIT-1, sample rxs, load rx_byte from the shift register, then go to IDLE.
  - rxs=1 and 0x41 ≤ byte ≤ 0x50: sel_out <= (byte - 0x41)[3:0] and pulse sel_valid.
  - rxs=1 and byte out of range: pulse char_err; sel_out is unchanged.
  - rxs=0: pulse frame_err only; sel_out is unchanged.
- Exactly one of sel_valid, char_err and frame_err pulses per completed frame. None pulse for a rejected start.
- After a frame error with the line still low, no new frame starts until the line returns high and then falls again, because start detection is edge-based.
- rxd activity during DATA or STOP does not restart the frame.
- Reset at any time, including mid-frame, forces the FSM to IDLE, clears the counter, index and shift register, and drives every output to its reset value.
- Reset values: rx_byte=0x00, sel_out=0, sel_valid=0, char_err=0, frame_err=0, busy=0.

## Timing
- All outputs are registered.
- Let E be the first clk edge at which the synchronised rxs reads 0, i.e. the edge at which the falling edge is detected.
- The start bit is sampled at E+HALF_BIT. Data bit k is sampled at E+HALF_BIT+(k+1)·CLKS_PER_BIT. The stop bit is sampled at E+HALF_BIT+9·CLKS_PER_BIT.
- rx_byte, sel_out and the pulse outputs update at the stop-sample edge and are visible for the cycle that follows. Each pulse lasts exactly 1 clk.
- busy rises at E and falls at the stop-sample edge, or at E+HALF_BIT on a rejected start.
- A new falling edge is accepted starting the cycle after the return to IDLE. Back-to-back frames with a 1-bit stop and no extra idle must be received without loss.
- Tolerates ±2% baud mismatch.

## Test plan
- Sim parameters for all scenarios: CLK_FREQ=160, BAUD=10, so CLKS_PER_BIT=16 and HALF_BIT=8.
- Basic decode: send 0x41 -> rx_byte=0x41, sel_out=0, one sel_valid pulse exactly 8+9·16 clks after E; no char_err or frame_err.
- Range ends, back-to-back: send 0x50, 0x4B, 0x42 with no idle between frames -> sel_out=15, then 10, then 1; three sel_valid pulses.
- Out of range: after sel_out=5, send 0x40 then 0x51 -> two char_err pulses; rx_byte=0x40 then 0x51; sel_out stays 5; no sel_valid.
- Framing error: send 0x43 with the stop bit low, hold the line low for 40 clks, then release high -> one frame_err; rx_byte=0x43; sel_out unchanged; no new frame starts while the line stays low.
- Glitch: drive rxd low for 4 clks from idle -> busy pulses for HALF_BIT clks; no output pulses; rx_byte unchanged.
- Reset mid-frame: assert rst_n=0 during data bit 3 of 0x45 -> all outputs reset immediately. Release reset, then send 0x46 -> sel_out=5 with a single sel_valid pulse.

Source files
------------

// File: rtl/uart_rx_sel_decoder.sv
// uart_rx_sel_decoder: 8N1 UART receiver that maps ASCII 'A'..'P' back to a
// 4-bit selector. Start detection is edge-based on the synchronised line; bits
// are sampled at mid-bit using a counter that restarts at every sample point.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   S_IDLE  | line idle, waiting for a high-to-low transition
//   S_START | counting to mid start bit, rejecting glitches
//   S_DATA  | sampling 8 data bits LSB-first, one per bit period
//   S_STOP  | sampling stop bit, then publishing byte / selector / error
module uart_rx_sel_decoder #(
   parameter int CLK_FREQ = 50_000_000,
   parameter int BAUD     = 9600
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rxd,
   output logic [7:0] rx_byte,
   output logic [3:0] sel_out,
   output logic       sel_valid,
   output logic       char_err,
   output logic       frame_err,
   output logic       busy
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
   localparam int HALF_BIT     = CLKS_PER_BIT / 2;
   localparam int CW           = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] CNT_BIT_END  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_HALF_END = CW'(HALF_BIT - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic            r_sync1;
   logic            r_rxs;
   logic            r_rxs_d;
   logic [CW-1:0]   r_cnt;
   logic [CW-1:0]   w_cnt_nxt;
   logic [2:0]      r_idx;
   logic [2:0]      w_idx_nxt;
   logic [7:0]      r_shift;
   logic [7:0]      w_shift_nxt;
   logic [7:0]      r_byte;
   logic [7:0]      w_byte_nxt;
   logic [3:0]      r_sel;
   logic [3:0]      w_sel_nxt;
   logic            r_valid;
   logic            w_valid_nxt;
   logic            r_cerr;
   logic            w_cerr_nxt;
   logic            r_ferr;
   logic            w_ferr_nxt;
   logic            w_in_range;
   logic [3:0]      w_sel_code;

   // 0x41..0x50 span one nibble wrap, and 0x40 is a multiple of 16, so
   // (byte - 0x41) mod 16 equals the low nibble minus one.
   assign w_in_range = (r_shift >= 8'h41) && (r_shift <= 8'h50);
   assign w_sel_code = r_shift[3:0] - 4'd1;

   // Two-flop synchroniser plus one delayed copy for edge detection; idle high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= 1'b1;
         r_rxs   <= 1'b1;
         r_rxs_d <= 1'b1;
      end else begin
         r_sync1 <= rxd;
         r_rxs   <= r_sync1;
         r_rxs_d <= r_rxs;
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_shift <= '0;
         r_byte  <= '0;
         r_sel   <= '0;
         r_valid <= 1'b0;
         r_cerr  <= 1'b0;
         r_ferr  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_idx   <= w_idx_nxt;
         r_shift <= w_shift_nxt;
         r_byte  <= w_byte_nxt;
         r_sel   <= w_sel_nxt;
         r_valid <= w_valid_nxt;
         r_cerr  <= w_cerr_nxt;
         r_ferr  <= w_ferr_nxt;
      end
   end

   // Next-state and next-output logic; the counter free-runs unless a sample point clears it.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt + CW'(1);
      w_idx_nxt   = r_idx;
      w_shift_nxt = r_shift;
      w_byte_nxt  = r_byte;
      w_sel_nxt   = r_sel;
      w_valid_nxt = 1'b0;
      w_cerr_nxt  = 1'b0;
      w_ferr_nxt  = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_cnt_nxt = '0;
            if (r_rxs_d && !r_rxs) begin
               w_state_nxt = S_START;
            end
         end
         S_START: begin
            if (r_cnt == CNT_HALF_END) begin
               w_cnt_nxt = '0;
               if (r_rxs) begin
                  w_state_nxt = S_IDLE;
               end else begin
                  w_idx_nxt   = '0;
                  w_state_nxt = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (r_cnt == CNT_BIT_END) begin
               w_cnt_nxt   = '0;
               w_shift_nxt = {r_rxs, r_shift[7:1]};
               w_idx_nxt   = r_idx + 3'd1;
               if (r_idx == 3'd7) begin
                  w_state_nxt = S_STOP;
               end
            end
         end
         S_STOP: begin
            if (r_cnt == CNT_BIT_END) begin
               w_cnt_nxt   = '0;
               w_byte_nxt  = r_shift;
               w_state_nxt = S_IDLE;
               if (!r_rxs) begin
                  w_ferr_nxt = 1'b1;
               end else if (w_in_range) begin
                  w_sel_nxt   = w_sel_code;
                  w_valid_nxt = 1'b1;
               end else begin
                  w_cerr_nxt = 1'b1;
               end
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   assign rx_byte   = r_byte;
   assign sel_out   = r_sel;
   assign sel_valid = r_valid;
   assign char_err  = r_cerr;
   assign frame_err = r_ferr;
   assign busy      = (r_state != S_IDLE);

endmodule
